// File: rtl/fetch_pkg.sv
// Shared types for the fetch stage: FSM state, queue entry and the address fault check.
// The check is only used when FETCH_FAULT_EN is defined.
package fetch_pkg;

    typedef enum logic [0:0] {
        FETCH   = 1'b0,
        FAULTED = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    localparam int unsigned DEF_WORD_BYTES = 4;
    localparam int unsigned WORD_BITS      = DEF_WORD_BYTES * 8;

    // Misaligned PC, or PC past the last full word of memory.
    function automatic logic addr_fault(input logic [31:0] pc,
                                        input logic [31:0] align_mask,
                                        input logic [31:0] last_pc);
        return ((pc & align_mask) != '0) || (pc > last_pc);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries with first-word-fall-through head.
// Flush and reset both empty it; a push into a full queue is taken only alongside a pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   flush,
    input  logic   push,
    input  entry_t push_entry,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR   = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    entry_t        storage [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = storage[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) storage[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, memory address drive, tagged instruction queue.
// Optional fetch-fault detection is enabled by defining FETCH_FAULT_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned WORD_SIZE_BYTES = 4,
    parameter int unsigned NUM_WORDS       = 1024,
    parameter logic [31:0] RESET_PC        = 32'h0,
    parameter int unsigned QUEUE_DEPTH     = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic        fault
);

    if (QUEUE_DEPTH < 2 || WORD_SIZE_BYTES == 0 ||
        (WORD_SIZE_BYTES & (WORD_SIZE_BYTES - 1)) != 0 ||
        WORD_SIZE_BYTES * 8 > WORD_BITS || NUM_WORDS < WORD_SIZE_BYTES) begin : g_param_check
        $error("fetch_unit: unsupported parameter set");
    end

    state_t      state;
    logic [31:0] pc;
    entry_t      head;
    entry_t      push_entry;
    logic        full;
    logic        empty;
    logic        pop;
    logic        attempt;
    logic        bad;
    logic        push;

    assign mem_addr    = pc;
    assign instr_valid = !empty;
    assign instr_data  = empty ? '0 : head.data;
    assign instr_pc    = empty ? '0 : head.pc;
    assign pop         = !empty && instr_ready;

    // A redirect suppresses the push; the popped head still counts as delivered.
    assign attempt    = (state == FETCH) && !redirect_valid && (!full || pop);
    assign push       = attempt && !bad;
    assign push_entry = '{pc: pc, data: mem_data};

`ifdef FETCH_FAULT_EN
    localparam logic [31:0] ALIGN_MASK = 32'(WORD_SIZE_BYTES - 1);
    localparam logic [31:0] LAST_PC    = 32'(NUM_WORDS - WORD_SIZE_BYTES);
    assign bad   = addr_fault(pc, ALIGN_MASK, LAST_PC);
    assign fault = (state == FAULTED);
`else
    assign bad   = 1'b0;
    assign fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_PC;
            state <= FETCH;
        end else if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= FETCH;
        end else if (push) begin
            pc <= pc + 32'(WORD_SIZE_BYTES);
        end else if (attempt && bad) begin
            state <= FAULTED;
        end
    end

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus a backpressure streaming sequence.
// Fault rows are included when FETCH_FAULT_EN is defined, wrap-around rows otherwise.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        fault;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Memory image: word at byte address 4*i holds 0x11111111*(i+1).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] idx;
        idx = (a >> 2) + 32'd1;
        return idx * 32'h11111111;
    endfunction

    assign mem_data = mem_word(mem_addr);

    fetch_unit #(
        .WORD_SIZE_BYTES (4),
        .NUM_WORDS       (1024),
        .RESET_PC        (32'h0),
        .QUEUE_DEPTH     (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .fault          (fault)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eaddr;
        logic        zero;
        logic        efault;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic ev, input logic [31:0] epc, input logic [31:0] eaddr,
                       input logic zero, input logic efault);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.eaddr = eaddr; v.zero = zero; v.efault = efault;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [29:0] pat;
        logic [31:0] exp_pc;
        logic [31:0] prev_pc;
        logic [31:0] prev_data;
        logic        prev_hold;
        int          delivered;
        int          want_delivered;

        // rst rv rpc rdy | valid pc addr zero fault  (one row per clock cycle)
        add(0, 0, 32'h0, 1,   0, 32'h0,  32'h0,  1, 0);
        add(0, 0, 32'h0, 1,   1, 32'h0,  32'h4,  0, 0);
        add(0, 0, 32'h0, 1,   1, 32'h4,  32'h8,  0, 0);
        add(0, 0, 32'h0, 1,   1, 32'h8,  32'hC,  0, 0);
        add(0, 0, 32'h0, 1,   1, 32'hC,  32'h10, 0, 0);
        add(1, 0, 32'h0, 1,   1, 32'h10, 32'h14, 0, 0);
        // backpressure: queue fills, pc holds at 8, then full push+pop keeps order
        add(0, 0, 32'h0, 0,   0, 32'h0,  32'h0,  1, 0);
        add(0, 0, 32'h0, 0,   1, 32'h0,  32'h4,  0, 0);
        add(0, 0, 32'h0, 0,   1, 32'h0,  32'h8,  0, 0);
        add(0, 0, 32'h0, 0,   1, 32'h0,  32'h8,  0, 0);
        add(0, 0, 32'h0, 0,   1, 32'h0,  32'h8,  0, 0);
        add(0, 0, 32'h0, 1,   1, 32'h0,  32'h8,  0, 0);
        add(0, 0, 32'h0, 1,   1, 32'h4,  32'hC,  0, 0);
        add(0, 0, 32'h0, 1,   1, 32'h8,  32'h10, 0, 0);
        add(0, 0, 32'h0, 1,   1, 32'hC,  32'h14, 0, 0);
        add(1, 0, 32'h0, 1,   1, 32'h10, 32'h18, 0, 0);
        // redirect to 0x40 in cycle 3
        add(0, 0, 32'h0,  1,  0, 32'h0,  32'h0,  1, 0);
        add(0, 0, 32'h0,  1,  1, 32'h0,  32'h4,  0, 0);
        add(0, 0, 32'h0,  1,  1, 32'h4,  32'h8,  0, 0);
        add(0, 1, 32'h40, 1,  1, 32'h8,  32'hC,  0, 0);
        add(0, 0, 32'h0,  1,  0, 32'h0,  32'h40, 0, 0);
        add(0, 0, 32'h0,  1,  1, 32'h40, 32'h44, 0, 0);
        add(0, 0, 32'h0,  0,  1, 32'h44, 32'h48, 0, 0);
        // reset wins over redirect with two entries queued
        add(1, 1, 32'h80, 0,  1, 32'h44, 32'h4C, 0, 0);
        add(0, 0, 32'h0,  1,  0, 32'h0,  32'h0,  1, 0);
        add(0, 0, 32'h0,  1,  1, 32'h0,  32'h4,  0, 0);
`ifndef FETCH_FAULT_EN
        add(0, 1, 32'hFFFF_FFFC, 1, 1, 32'h4,         32'h8,         0, 0);
        add(0, 0, 32'h0,         1, 0, 32'h0,         32'hFFFF_FFFC, 0, 0);
        add(0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 32'h0,         0, 0);
        add(0, 0, 32'h0,         1, 1, 32'h0,         32'h4,         0, 0);
`else
        add(0, 1, 32'h402, 1, 1, 32'h4,   32'h8,   0, 0);
        add(0, 0, 32'h0,   1, 0, 32'h0,   32'h402, 0, 0);
        add(0, 0, 32'h0,   1, 0, 32'h0,   32'h402, 0, 1);
        add(0, 1, 32'h0,   1, 0, 32'h0,   32'h402, 0, 1);
        add(0, 0, 32'h0,   1, 0, 32'h0,   32'h0,   0, 0);
        add(0, 0, 32'h0,   1, 1, 32'h0,   32'h4,   0, 0);
        add(0, 1, 32'h3FC, 1, 1, 32'h4,   32'h8,   0, 0);
        add(0, 0, 32'h0,   1, 0, 32'h0,   32'h3FC, 0, 0);
        add(0, 0, 32'h0,   1, 1, 32'h3FC, 32'h400, 0, 0);
        add(0, 0, 32'h0,   1, 0, 32'h0,   32'h400, 0, 1);
        add(1, 0, 32'h0,   1, 0, 32'h0,   32'h400, 0, 1);
        add(0, 0, 32'h0,   1, 0, 32'h0,   32'h0,   1, 0);
`endif

        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;
        repeat (3) @(negedge clk);

        foreach (vecs[i]) begin
            reset          = vecs[i].rst;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            instr_ready    = vecs[i].rdy;
            #1;
            check($sformatf("row%0d instr_valid", i), 32'(instr_valid), 32'(vecs[i].ev));
            check($sformatf("row%0d mem_addr", i), mem_addr, vecs[i].eaddr);
            check($sformatf("row%0d fault", i), 32'(fault), 32'(vecs[i].efault));
            if (vecs[i].ev) begin
                check($sformatf("row%0d instr_pc", i), instr_pc, vecs[i].epc);
                check($sformatf("row%0d instr_data", i), instr_data, mem_word(vecs[i].epc));
            end
            if (vecs[i].zero) begin
                check($sformatf("row%0d reset instr_pc", i), instr_pc, 32'h0);
                check($sformatf("row%0d reset instr_data", i), instr_data, 32'h0);
            end
            @(negedge clk);
        end

        // Streaming under irregular backpressure: in-order, no gaps, stable head while stalled.
        reset          = 1'b1;
        redirect_valid = 1'b0;
        instr_ready    = 1'b0;
        @(negedge clk);
        reset          = 1'b0;
        pat            = 30'b1011_0011_1000_1111_0110_0101_1101_10;
        exp_pc         = 32'h0;
        prev_hold      = 1'b0;
        prev_pc        = '0;
        prev_data      = '0;
        delivered      = 0;
        want_delivered = 0;
        for (int k = 0; k < 30; k++) begin
            instr_ready = pat[k];
            #1;
            if (k >= 1) begin
                check($sformatf("stream%0d valid", k), 32'(instr_valid), 32'h1);
                if (pat[k]) want_delivered++;
            end
            if (prev_hold) begin
                check($sformatf("stream%0d held pc", k), instr_pc, prev_pc);
                check($sformatf("stream%0d held data", k), instr_data, prev_data);
            end
            if (instr_valid && instr_ready) begin
                check($sformatf("stream%0d pc", k), instr_pc, exp_pc);
                check($sformatf("stream%0d data", k), instr_data, mem_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            prev_hold = instr_valid && !instr_ready;
            prev_pc   = instr_pc;
            prev_data = instr_data;
            @(negedge clk);
        end
        check("stream delivered count", 32'(delivered), 32'(want_delivered));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
